// File: rtl/ser2par_latch_loader_pkg.sv
// Shared definitions for the serial-to-parallel latch loader: FSM state
// encodings and default geometry.
package ser2par_latch_loader_pkg;

    typedef enum logic [1:0] {
        SHIFT  = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_WIDTH         = 8;
    localparam int unsigned DEFAULT_STROBE_CYCLES = 2;

endpackage

// File: rtl/ser2par_shift_core.sv
// LSB-first serial assembler: collects bits and flags the edge on which the
// final bit of a word arrives, presenting the complete word alongside.
module ser2par_shift_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_bar,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic [WIDTH-1:0] word,
    output logic             word_done
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Only the upper WIDTH-1 bits of the full shift register ever reach a
    // completed word; the bit that would fall into position 0 is never used.
    logic [WIDTH-2:0] shift_reg;
    logic [CW-1:0]    bit_count;

    assign word      = {ser_in, shift_reg};
    assign word_done = shift_en && (bit_count == LAST);

    always_ff @(posedge clock or negedge reset_bar) begin
        if (!reset_bar) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (clear) begin
            shift_reg <= '0;
            bit_count <= '0;
        end else if (shift_en) begin
            shift_reg <= word[WIDTH-1:1];
            if (word_done) begin
                bit_count <= '0;
            end else begin
                bit_count <= bit_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ser2par_latch_loader.sv
// Feeds a transparent latch bank: assembles a serial word, then opens a
// registered latch_enable window with one clock of setup and hold around it.
module ser2par_latch_loader
    import ser2par_latch_loader_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned STROBE_CYCLES = DEFAULT_STROBE_CYCLES
) (
    input  logic             clock,
    input  logic             reset_bar,
    input  logic             ser_in,
    input  logic             bit_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] data_out,
    output logic             latch_enable,
    output logic             ready,
    output logic             overrun
);

    localparam int unsigned SW = $clog2(STROBE_CYCLES + 1);
    localparam logic [SW-1:0] STROBE_LAST = SW'(STROBE_CYCLES);

    state_t           state;
    logic [SW-1:0]    strobe_cnt;
    logic             shift_en;
    logic [WIDTH-1:0] word;
    logic             word_done;

    assign shift_en = bit_valid && ready && !clear;

    ser2par_shift_core #(
        .WIDTH(WIDTH)
    ) u_shift_core (
        .clock     (clock),
        .reset_bar (reset_bar),
        .clear     (clear),
        .shift_en  (shift_en),
        .ser_in    (ser_in),
        .word      (word),
        .word_done (word_done)
    );

    // ready mirrors state==SHIFT but is kept as its own flop so it is
    // available as a clean registered output.
    always_ff @(posedge clock or negedge reset_bar) begin
        if (!reset_bar) begin
            state        <= SHIFT;
            strobe_cnt   <= '0;
            data_out     <= '0;
            latch_enable <= 1'b0;
            ready        <= 1'b1;
            overrun      <= 1'b0;
        end else if (clear) begin
            state        <= SHIFT;
            strobe_cnt   <= '0;
            latch_enable <= 1'b0;
            ready        <= 1'b1;
            overrun      <= 1'b0;
        end else begin
            if (bit_valid && !ready) begin
                overrun <= 1'b1;
            end
            case (state)
                SHIFT: begin
                    if (word_done) begin
                        data_out <= word;
                        state    <= SETUP;
                        ready    <= 1'b0;
                    end
                end
                SETUP: begin
                    state        <= STROBE;
                    latch_enable <= 1'b1;
                    strobe_cnt   <= SW'(1);
                end
                STROBE: begin
                    if (strobe_cnt == STROBE_LAST) begin
                        state        <= HOLD;
                        latch_enable <= 1'b0;
                        strobe_cnt   <= '0;
                    end else begin
                        strobe_cnt <= strobe_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    state <= SHIFT;
                    ready <= 1'b1;
                end
                default: begin
                    state        <= SHIFT;
                    latch_enable <= 1'b0;
                    ready        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser2par_latch_loader.sv
// Self-checking bench for ser2par_latch_loader: vector table, directed corner
// sequences and randomized traffic against a frame-level reference model.
module tb_ser2par_latch_loader;

    localparam int W = 8;
    localparam int S = 2;

    logic         clock = 1'b0;
    logic         reset_bar = 1'b1;
    logic         ser_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] data_out;
    logic         latch_enable;
    logic         ready;
    logic         overrun;

    ser2par_latch_loader #(
        .WIDTH(W),
        .STROBE_CYCLES(S)
    ) dut (
        .clock        (clock),
        .reset_bar    (reset_bar),
        .ser_in       (ser_in),
        .bit_valid    (bit_valid),
        .clear        (clear),
        .data_out     (data_out),
        .latch_enable (latch_enable),
        .ready        (ready),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: bits gathered by position, busy window counted in
    // clocks since the word completed (-1 means accepting bits).
    int           m_cnt;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_data;
    int           m_k;
    logic         m_ovr;

    logic [W-1:0] q_out;
    logic         prev_le;
    int           run_len;
    int           pulse_lens[$];

    typedef struct {
        logic         bv;
        logic         b;
        logic         clr;
        logic [W-1:0] exp_data;
        logic         exp_le;
        logic         exp_ready;
    } vec_t;

    vec_t tbl[12];

    function automatic logic m_le();
        return (m_k >= 1) && (m_k <= S);
    endfunction

    function automatic logic m_ready();
        return m_k < 0;
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_acc  = '0;
        m_data = '0;
        m_k    = -1;
        m_ovr  = 1'b0;
    endtask

    task automatic model_step(input logic bv, input logic b, input logic clr);
        if (clr) begin
            m_cnt = 0;
            m_acc = '0;
            m_k   = -1;
            m_ovr = 1'b0;
        end else if (m_k < 0) begin
            if (bv) begin
                m_acc[m_cnt] = b;
                m_cnt++;
                if (m_cnt == W) begin
                    m_data = m_acc;
                    m_acc  = '0;
                    m_cnt  = 0;
                    m_k    = 0;
                end
            end
        end else begin
            if (bv) m_ovr = 1'b1;
            m_k++;
            if (m_k == S + 2) m_k = -1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("latch_enable", 32'(latch_enable), 32'(m_le()));
        chk("ready", 32'(ready), 32'(m_ready()));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic cycle(input logic bv, input logic b, input logic clr);
        bit_valid = bv;
        ser_in    = b;
        clear     = clr;
        @(posedge clock);
        model_step(bv, b, clr);
        #1;
        check_model();
        if (latch_enable) q_out = data_out;
        if (latch_enable && !prev_le) run_len = 1;
        else if (latch_enable) run_len++;
        else if (prev_le) pulse_lens.push_back(run_len);
        prev_le = latch_enable;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) cycle(1'b1, w[i], 1'b0);
    endtask

    task automatic do_reset();
        bit_valid = 1'b0;
        ser_in    = 1'b0;
        clear     = 1'b0;
        reset_bar = 1'b0;
        model_reset();
        q_out   = '0;
        prev_le = 1'b0;
        #1;
        check_model();
        @(negedge clock);
        reset_bar = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a5;
        a5 = 8'hA5;
        for (int i = 0; i < W; i++) begin
            tbl[i].bv        = 1'b1;
            tbl[i].b         = a5[i];
            tbl[i].clr       = 1'b0;
            tbl[i].exp_data  = (i == W - 1) ? a5 : '0;
            tbl[i].exp_le    = 1'b0;
            tbl[i].exp_ready = (i == W - 1) ? 1'b0 : 1'b1;
        end
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};

        #2;
        do_reset();

        // Basic frame 0xA5 from the vector table
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].bv, tbl[i].b, tbl[i].clr);
            chk("tbl_data", 32'(data_out), 32'(tbl[i].exp_data));
            chk("tbl_le", 32'(latch_enable), 32'(tbl[i].exp_le));
            chk("tbl_ready", 32'(ready), 32'(tbl[i].exp_ready));
        end
        chk("q_out_a5", 32'(q_out), 32'h0A5);

        // Gapped bit_valid: one bit every third clock
        do_reset();
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, a5[i], 1'b0);
            if (i < W - 1) begin
                chk("gap_data_early", 32'(data_out), 32'h0);
                chk("gap_le_early", 32'(latch_enable), 32'h0);
                idle(2);
                chk("gap_le_idle", 32'(latch_enable), 32'h0);
            end
        end
        chk("gap_data", 32'(data_out), 32'h0A5);
        idle(4);

        // bit_valid during STROBE sets overrun without disturbing the word
        send_word(8'hA5);
        idle(1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_data_kept", 32'(data_out), 32'h0A5);
        idle(2);
        send_word(8'h3C);
        chk("ovr_next_frame", 32'(data_out), 32'h03C);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        idle(4);
        cycle(1'b0, 1'b0, 1'b1);
        chk("ovr_cleared", 32'(overrun), 32'h0);

        // Aborted partial frame leaves no residue
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        send_word(8'hC3);
        chk("abort_data", 32'(data_out), 32'h0C3);
        idle(4);

        // Reset between clock edges in the middle of STROBE
        send_word(8'hA5);
        idle(1);
        chk("mid_strobe_le", 32'(latch_enable), 32'h1);
        #2;
        reset_bar = 1'b0;
        #1;
        chk("async_rst_le", 32'(latch_enable), 32'h0);
        chk("async_rst_data", 32'(data_out), 32'h0);
        model_reset();
        q_out   = '0;
        prev_le = 1'b0;
        @(negedge clock);
        reset_bar = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        chk("post_rst_ready", 32'(ready), 32'h1);

        // Back-to-back frames, second starting on the first accepted edge
        pulse_lens.delete();
        send_word(8'h3C);
        chk("b2b_data1", 32'(data_out), 32'h03C);
        idle(S + 2);
        send_word(8'hC3);
        chk("b2b_data2", 32'(data_out), 32'h0C3);
        idle(S + 2);
        chk("b2b_overrun", 32'(overrun), 32'h0);
        chk("b2b_pulses", 32'(pulse_lens.size()), 32'd2);
        foreach (pulse_lens[i]) chk("b2b_pulse_len", 32'(pulse_lens[i]), 32'(S));

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
